// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, stability filter FSM,
// mode-selected event pulses, sticky flags and saturating event counters.
module multi_edge_detect #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 3,
   parameter int CNT_W       = 8
) (
   input  logic                   in_clk,
   input  logic                   in_rst_n,
   input  logic [WIDTH-1:0]       in_i,
   input  logic [1:0]             in_mode,
   input  logic                   in_en,
   input  logic                   in_clr,
   output logic [WIDTH-1:0]       o_pulse,
   output logic [WIDTH-1:0]       o_rise,
   output logic [WIDTH-1:0]       o_fall,
   output logic [WIDTH-1:0]       o_flag,
   output logic [WIDTH*CNT_W-1:0] o_cnt,
   output logic                   o_any
);

   localparam int FCW = $clog2(FILT_CYCLES + 1);
   localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      STABLE_L = 2'd0,
      ARM_H    = 2'd1,
      STABLE_H = 2'd2,
      ARM_L    = 2'd3
   } state_t;

   logic [WIDTH-1:0] sample_s;
   logic             rise_sel_s;
   logic             fall_sel_s;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign sample_s = in_i;
   end else begin : g_sync
      logic [WIDTH-1:0] sync_r [SYNC_STAGES];

      // synchroniser shift chain
      always_ff @(posedge in_clk) begin
         if (!in_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
               sync_r[s] <= '0;
            end
         end else begin
            sync_r[0] <= in_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
               sync_r[s] <= sync_r[s-1];
            end
         end
      end

      assign sample_s = sync_r[SYNC_STAGES-1];
   end

   // mode decode; 11 leaves both selects low
   always_comb begin
      rise_sel_s = 1'b0;
      fall_sel_s = 1'b0;
      case (in_mode)
         2'b00:   begin rise_sel_s = 1'b1; fall_sel_s = 1'b0; end
         2'b01:   begin rise_sel_s = 1'b0; fall_sel_s = 1'b1; end
         2'b10:   begin rise_sel_s = 1'b1; fall_sel_s = 1'b1; end
         default: begin rise_sel_s = 1'b0; fall_sel_s = 1'b0; end
      endcase
   end

   for (genvar k = 0; k < WIDTH; k++) begin : g_ch
      state_t           state_r;
      state_t           state_nx;
      logic [FCW-1:0]   fcnt_r;
      logic [FCW-1:0]   fcnt_nx;
      logic             rise_ev_s;
      logic             fall_ev_s;
      logic             pulse_s;
      logic [CNT_W-1:0] cnt_base_s;
      logic [CNT_W-1:0] cnt_r;
      logic             pulse_r;
      logic             rise_r;
      logic             fall_r;
      logic             flag_r;

      // filter next-state: a level change must persist FILT_CYCLES samples
      always_comb begin
         state_nx  = state_r;
         fcnt_nx   = fcnt_r;
         rise_ev_s = 1'b0;
         fall_ev_s = 1'b0;
         case (state_r)
            STABLE_L: begin
               if (sample_s[k]) begin
                  if (FILT_CYCLES == 1) begin
                     state_nx  = STABLE_H;
                     fcnt_nx   = '0;
                     rise_ev_s = 1'b1;
                  end else begin
                     state_nx = ARM_H;
                     fcnt_nx  = FCW'(1);
                  end
               end else begin
                  state_nx = STABLE_L;
                  fcnt_nx  = '0;
               end
            end
            ARM_H: begin
               if (sample_s[k]) begin
                  if (fcnt_r + FCW'(1) == FILT_LAST) begin
                     state_nx  = STABLE_H;
                     fcnt_nx   = '0;
                     rise_ev_s = 1'b1;
                  end else begin
                     state_nx = ARM_H;
                     fcnt_nx  = fcnt_r + FCW'(1);
                  end
               end else begin
                  state_nx = STABLE_L;
                  fcnt_nx  = '0;
               end
            end
            STABLE_H: begin
               if (!sample_s[k]) begin
                  if (FILT_CYCLES == 1) begin
                     state_nx  = STABLE_L;
                     fcnt_nx   = '0;
                     fall_ev_s = 1'b1;
                  end else begin
                     state_nx = ARM_L;
                     fcnt_nx  = FCW'(1);
                  end
               end else begin
                  state_nx = STABLE_H;
                  fcnt_nx  = '0;
               end
            end
            ARM_L: begin
               if (!sample_s[k]) begin
                  if (fcnt_r + FCW'(1) == FILT_LAST) begin
                     state_nx  = STABLE_L;
                     fcnt_nx   = '0;
                     fall_ev_s = 1'b1;
                  end else begin
                     state_nx = ARM_L;
                     fcnt_nx  = fcnt_r + FCW'(1);
                  end
               end else begin
                  state_nx = STABLE_H;
                  fcnt_nx  = '0;
               end
            end
            default: begin
               state_nx = STABLE_L;
               fcnt_nx  = '0;
            end
         endcase
      end

      // filter state register
      always_ff @(posedge in_clk) begin
         if (!in_rst_n) begin
            state_r <= STABLE_L;
            fcnt_r  <= '0;
         end else begin
            state_r <= state_nx;
            fcnt_r  <= fcnt_nx;
         end
      end

      assign pulse_s = in_en & ((rise_ev_s & rise_sel_s) | (fall_ev_s & fall_sel_s));

      // clear is applied before the same-cycle event so no event is lost
      always_comb begin
         if (in_clr) begin
            cnt_base_s = '0;
         end else begin
            cnt_base_s = cnt_r;
         end
      end

      // registered event outputs, sticky flag and saturating counter
      always_ff @(posedge in_clk) begin
         if (!in_rst_n) begin
            pulse_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            flag_r  <= 1'b0;
            cnt_r   <= '0;
         end else begin
            pulse_r <= pulse_s;
            rise_r  <= in_en & rise_ev_s;
            fall_r  <= in_en & fall_ev_s;
            if (pulse_s) begin
               flag_r <= 1'b1;
            end else if (in_clr) begin
               flag_r <= 1'b0;
            end else begin
               flag_r <= flag_r;
            end
            if (pulse_s && (cnt_base_s != CNT_MAX)) begin
               cnt_r <= cnt_base_s + CNT_W'(1);
            end else begin
               cnt_r <= cnt_base_s;
            end
         end
      end

      assign o_pulse[k]              = pulse_r;
      assign o_rise[k]               = rise_r;
      assign o_fall[k]               = fall_r;
      assign o_flag[k]               = flag_r;
      assign o_cnt[k*CNT_W +: CNT_W] = cnt_r;
   end

   assign o_any = |o_pulse;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect: default, narrow-counter and
// unsynchronised/unfiltered instances share one stimulus stream.
module tb_multi_edge_detect;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_i;
   logic [1:0]  mode;
   logic        en;
   logic        clr;

   logic [3:0]  pa, ra, fa, fla;
   logic [31:0] cnta;
   logic        anya;
   logic [3:0]  pb, rb, fb, flb;
   logic [7:0]  cntb;
   logic        anyb;
   logic [3:0]  pc, rc, fc, flc;
   logic [31:0] cntc;
   logic        anyc;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0]  in_i;
      logic [1:0]  mode;
      logic        en;
      logic [3:0]  pulse;
      logic [3:0]  rise;
      logic [3:0]  fall;
      logic [3:0]  flag;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   multi_edge_detect dut_a (
      .in_clk(clk), .in_rst_n(rst_n), .in_i(in_i), .in_mode(mode), .in_en(en),
      .in_clr(clr), .o_pulse(pa), .o_rise(ra), .o_fall(fa), .o_flag(fla),
      .o_cnt(cnta), .o_any(anya)
   );

   multi_edge_detect #(.CNT_W(2)) dut_b (
      .in_clk(clk), .in_rst_n(rst_n), .in_i(in_i), .in_mode(mode), .in_en(en),
      .in_clr(clr), .o_pulse(pb), .o_rise(rb), .o_fall(fb), .o_flag(flb),
      .o_cnt(cntb), .o_any(anyb)
   );

   multi_edge_detect #(.SYNC_STAGES(0), .FILT_CYCLES(1)) dut_c (
      .in_clk(clk), .in_rst_n(rst_n), .in_i(in_i), .in_mode(mode), .in_en(en),
      .in_clr(clr), .o_pulse(pc), .o_rise(rc), .o_fall(fc), .o_flag(flc),
      .o_cnt(cntc), .o_any(anyc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic add(input int n, input logic [3:0] vi, input logic [1:0] vm, input logic ve,
                      input logic [3:0] vp, input logic [3:0] vr, input logic [3:0] vf,
                      input logic [3:0] vfl, input logic [31:0] vc);
      vec_t v;
      v.in_i = vi; v.mode = vm; v.en = ve;
      v.pulse = vp; v.rise = vr; v.fall = vf; v.flag = vfl; v.cnt = vc;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   initial begin
      int sat;
      rst_n = 1'b0; in_i = 4'h0; mode = 2'b00; en = 1'b1; clr = 1'b0;
      repeat (3) step();
      chk("rst_a_pulse", 32'(pa), 32'h0);
      chk("rst_a_flag",  32'(fla), 32'h0);
      chk("rst_a_cnt",   cnta, 32'h0);
      chk("rst_a_any",   32'(anya), 32'h0);
      chk("rst_b_cnt",   32'(cntb), 32'h0);
      chk("rst_c_pulse", 32'(pc), 32'h0);
      chk("rst_c_cnt",   cntc, 32'h0);
      rst_n = 1'b1;
      step();

      // single rise on ch0, latency 5
      add(4, 4'b0001, 2'b00, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
      add(1, 4'b0001, 2'b00, 1'b1, 4'h1, 4'h1, 4'h0, 4'h1, 32'h1);
      add(3, 4'b0001, 2'b00, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1, 32'h1);
      // 2-cycle glitch on ch1 rejected
      add(2, 4'b0011, 2'b00, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1, 32'h1);
      add(6, 4'b0001, 2'b00, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1, 32'h1);
      // 3-cycle pulse on ch1, both edges
      add(3, 4'b0011, 2'b10, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1, 32'h1);
      add(1, 4'b0001, 2'b10, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1, 32'h1);
      add(1, 4'b0001, 2'b10, 1'b1, 4'h2, 4'h2, 4'h0, 4'h3, 32'h101);
      add(2, 4'b0001, 2'b10, 1'b1, 4'h0, 4'h0, 4'h0, 4'h3, 32'h101);
      add(1, 4'b0001, 2'b10, 1'b1, 4'h2, 4'h0, 4'h2, 4'h3, 32'h201);
      add(2, 4'b0001, 2'b10, 1'b1, 4'h0, 4'h0, 4'h0, 4'h3, 32'h201);
      // falling-only mode on ch2
      add(4, 4'b0101, 2'b01, 1'b1, 4'h0, 4'h0, 4'h0, 4'h3, 32'h201);
      add(1, 4'b0101, 2'b01, 1'b1, 4'h0, 4'h4, 4'h0, 4'h3, 32'h201);
      add(5, 4'b0101, 2'b01, 1'b1, 4'h0, 4'h0, 4'h0, 4'h3, 32'h201);
      add(4, 4'b0001, 2'b01, 1'b1, 4'h0, 4'h0, 4'h0, 4'h3, 32'h201);
      add(1, 4'b0001, 2'b01, 1'b1, 4'h4, 4'h0, 4'h4, 4'h7, 32'h10201);
      add(5, 4'b0001, 2'b01, 1'b1, 4'h0, 4'h0, 4'h0, 4'h7, 32'h10201);
      // ch3 rise while disabled, fall reported once enabled
      add(8, 4'b1001, 2'b10, 1'b0, 4'h0, 4'h0, 4'h0, 4'h7, 32'h10201);
      add(4, 4'b0001, 2'b10, 1'b1, 4'h0, 4'h0, 4'h0, 4'h7, 32'h10201);
      add(1, 4'b0001, 2'b10, 1'b1, 4'h8, 4'h0, 4'h8, 4'hF, 32'h01010201);
      add(2, 4'b0001, 2'b10, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 32'h01010201);

      foreach (vecs[i]) begin
         in_i = vecs[i].in_i; mode = vecs[i].mode; en = vecs[i].en;
         step();
         chk($sformatf("v%0d_pulse", i), 32'(pa), 32'(vecs[i].pulse));
         chk($sformatf("v%0d_rise", i),  32'(ra), 32'(vecs[i].rise));
         chk($sformatf("v%0d_fall", i),  32'(fa), 32'(vecs[i].fall));
         chk($sformatf("v%0d_flag", i),  32'(fla), 32'(vecs[i].flag));
         chk($sformatf("v%0d_cnt", i),   cnta, vecs[i].cnt);
         chk($sformatf("v%0d_any", i),   32'(anya), 32'(|vecs[i].pulse));
      end

      // reset while ch1 is arming, then re-report held-high inputs
      mode = 2'b10; en = 1'b1; in_i = 4'b0011;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      chk("mid_rst_pulse", 32'(pa), 32'h0);
      chk("mid_rst_flag",  32'(fla), 32'h0);
      chk("mid_rst_cnt",   cnta, 32'h0);
      chk("mid_rst_any",   32'(anya), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_quiet", 32'(pa), 32'h0);
      end
      step();
      chk("post_rst_pulse", 32'(pa), 32'h3);
      chk("post_rst_rise",  32'(ra), 32'h3);
      chk("post_rst_cnt",   cnta, 32'h101);

      // counter saturation on the 2-bit instance
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("b_clr_cnt",  32'(cntb), 32'h0);
      chk("b_clr_flag", 32'(flb), 32'h0);
      for (int t = 1; t <= 5; t++) begin
         in_i[3] = ~in_i[3];
         repeat (4) step();
         step();
         sat = (t > 3) ? 3 : t;
         chk($sformatf("b_sat%0d_pulse", t), 32'(pb), 32'h8);
         chk($sformatf("b_sat%0d_cnt", t), 32'(cntb), 32'(sat << 6));
      end
      in_i[3] = ~in_i[3];
      repeat (4) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("b_clr_evt_pulse", 32'(pb), 32'h8);
      chk("b_clr_evt_cnt",   32'(cntb), 32'h40);
      chk("b_clr_evt_flag",  32'(flb), 32'h8);

      // unsynchronised, unfiltered instance: all channels change together
      clr = 1'b1;
      step();
      clr = 1'b0;
      in_i = 4'b1100;
      step();
      chk("c_all_pulse", 32'(pc), 32'hF);
      chk("c_all_any",   32'(anyc), 32'h1);
      chk("c_all_rise",  32'(rc), 32'hC);
      chk("c_all_fall",  32'(fc), 32'h3);
      chk("c_all_cnt",   cntc, 32'h01010101);
      step();
      chk("c_after_pulse", 32'(pc), 32'h0);
      chk("c_after_any",   32'(anyc), 32'h0);

      // toggling faster than the filter never yields an event
      repeat (6) step();
      for (int j = 0; j < 12; j++) begin
         if (j % 2 == 0) in_i[0] = ~in_i[0];
         step();
         chk("fast_pulse", 32'(pa), 32'h0);
         chk("fast_rise",  32'(ra), 32'h0);
         chk("fast_fall",  32'(fa), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
